// File: rtl/ram_8x4_writer.sv
// 8x4 RAM loaded through an auto-incrementing valid/ready write stream.
// Contents are zeroed by a clear pass after reset or on request.
module ram_8x4_writer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_FULL
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   clr_ptr_n;
    logic [ADDR_W-1:0]   wr_ptr_n;
    logic [ADDR_W:0]     count_n;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state   <= state_n;
            clr_ptr <= clr_ptr_n;
            wr_ptr  <= wr_ptr_n;
            count   <= count_n;
        end
    end

    // One shared write port: the clear pass and the load stream never overlap.
    always_comb begin
        state_n   = state;
        clr_ptr_n = clr_ptr;
        wr_ptr_n  = wr_ptr;
        count_n   = count;
        mem_we    = 1'b0;
        mem_addr  = wr_ptr;
        mem_wdata = wr_data;
        wr_ready  = 1'b0;
        unique case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr;
                mem_wdata = '0;
                clr_ptr_n = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    clr_ptr_n = '0;
                    wr_ptr_n  = '0;
                    count_n   = '0;
                    state_n   = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_ready = !clr;
                if (clr) begin
                    state_n   = S_CLEAR;
                    clr_ptr_n = '0;
                end else if (wr_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_n = wr_ptr + 1'b1;
                    count_n  = count + 1'b1;
                    if (count == LAST_CNT) begin
                        state_n = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (clr) begin
                    state_n   = S_CLEAR;
                    clr_ptr_n = '0;
                end
            end
            default: begin
                state_n = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Non-blocking update gives read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    assign full = (count == FULL_CNT);
    assign busy = (state == S_CLEAR);

endmodule

// File: tb/tb_ram_8x4_writer.sv
// Bench for ram_8x4_writer: reference memory model feeds a queue of
// expected read data that a monitor pops one cycle after each read.
module tb_ram_8x4_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    logic [2:0] wr_ptr;
    logic [3:0] count;
    logic       full;
    logic       busy;

    ram_8x4_writer dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_ptr   (wr_ptr),
        .count    (count),
        .full     (full),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] ref_mem [8];
    int         exp_ptr;
    int         exp_cnt;
    logic [3:0] exp_q [$];
    logic [3:0] stream [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rd_en && !rst) begin
            @(negedge clk);
            if (exp_q.size() == 0) chk("rd_q_empty", 0, 1);
            else chk("rd_data", {28'd0, rd_data}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 8; i++) ref_mem[i] = 4'h0;
        exp_ptr = 0;
        exp_cnt = 0;
    endtask

    task automatic rd(input int a);
        rd_en   = 1'b1;
        rd_addr = 3'(a);
        exp_q.push_back(ref_mem[a]);
        @(negedge clk);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) rd(i);
        rd_en = 1'b0;
    endtask

    task automatic put(input logic [3:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_cnt < 8});
        if (exp_cnt < 8) begin
            ref_mem[exp_ptr] = d;
            exp_ptr = (exp_ptr + 1) % 8;
            exp_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        int early = 0;
        while (busy && n < 40) begin
            if (wr_ready) early++;
            n++;
            @(negedge clk);
        end
        chk(tag, n, 8);
        chk("early_ready", early, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        stream = '{4'h0, 4'h2, 4'h6, 4'h9, 4'h1, 4'h9, 4'hC, 4'hF};
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_data = 4'h0;
        rd_en = 1'b0; rd_addr = 3'd0;
        clear_model();
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_ptr", wr_ptr, 0);
        chk("rst_full", full, 0);
        chk("rst_rd", rd_data, 0);
        rst = 1'b0;
        wait_clear("rst_busy_len");
        chk("post_ready", wr_ready, 1);
        chk("post_count", count, 0);
        read_all();

        foreach (stream[i]) put(stream[i]);
        wr_valid = 1'b0;
        chk("ld_full", full, 1);
        chk("ld_count", count, 8);
        chk("ld_ptr", wr_ptr, 0);
        chk("ld_ready", wr_ready, 0);
        put(4'hE);
        put(4'hE);
        wr_valid = 1'b0;
        read_all();
        chk("still_full", full, 1);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_keep_cnt", count, 8);
        wait_clear("clr_busy_len");
        chk("clr_count", count, 0);
        chk("clr_ptr", wr_ptr, 0);
        clear_model();

        for (int i = 0; i < 8; i++) begin
            put(4'((i * 5 + 2) % 16));
            wr_valid = 1'b0;
            wr_data  = 4'hF;
            @(negedge clk);
        end
        chk("gap_full", full, 1);
        chk("gap_count", count, 8);
        read_all();

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_clear("clr2_busy_len");
        clear_model();
        put(4'h3);
        put(4'h4);
        put(4'h5);
        wr_valid = 1'b0;
        chk("col_count", count, 3);
        chk("col_ptr", wr_ptr, 3);
        clr = 1'b1;
        wr_valid = 1'b1;
        wr_data = 4'hA;
        #1;
        chk("col_ready", wr_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        wr_valid = 1'b0;
        chk("col_keep_cnt", count, 3);
        wait_clear("col_busy_len");
        chk("col_count0", count, 0);
        clear_model();
        read_all();

        wr_valid = 1'b1;
        wr_data = 4'h5;
        rd_en = 1'b1;
        rd_addr = 3'd0;
        exp_q.push_back(ref_mem[0]);
        ref_mem[0] = 4'h5;
        exp_ptr = 1;
        exp_cnt = 1;
        @(negedge clk);
        wr_valid = 1'b0;
        rd(0);
        rd_en = 1'b0;
        rd_addr = 3'd3;
        @(negedge clk);
        @(negedge clk);
        chk("rd_hold", rd_data, 5);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_rd", rd_data, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_ptr", wr_ptr, 0);
        wait_clear("mid_busy_len");
        chk("mid_ready", wr_ready, 1);
        clear_model();
        read_all();

        @(negedge clk);
        chk("q_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_8x4_writer.md
# ram_8x4_writer

Write-side counterpart to the team's 8x4 ROM read path: an 8-word x 4-bit RAM loaded through a valid/ready write stream at auto-incrementing addresses, with a registered read port that has the same enable/address/data shape as the ROM. Three blocks use it to load lookup tables at run time instead of relying on fixed initial contents:

- a programming source,
- a self-test sequencer,
- a host loader.

A built-in clear sequencer zeroes all words after reset and on request, so memory contents are always defined.

## Interface
Parameters:
- DATA_W, 4, word width
- DEPTH, 8, number of words (power of two)
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- clr  input  1  single-cycle request to zero all words and rewind the write pointer
- wr_valid  input  1  source has a word on wr_data
- wr_data  input  DATA_W  word to store
- wr_ready  output  1  block accepts a word this cycle
- rd_en  input  1  read enable
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  registered read data
- wr_ptr  output  ADDR_W  address the next accepted word will be written to
- count  output  ADDR_W+1  number of words written since the last clear (0..DEPTH)
- full  output  1  count == DEPTH
- busy  output  1  clear sequence in progress

## Operation
- The FSM has three states: CLEAR, LOAD and FULL.
- **CLEAR**
  - Each cycle writes 0 to mem[clr_ptr], then increments clr_ptr.
  - After mem[DEPTH-1] is written: clr_ptr=0, wr_ptr=0, count=0, next state LOAD.
  - busy=1 and wr_ready=0 throughout.
  - clr is ignored; the sequence is not restarted.
- **LOAD**
  - wr_ready = !clr.
  - On wr_valid && wr_ready: mem[wr_ptr] <= wr_data, then wr_ptr++ and count++.
  - When count reaches DEPTH, next state FULL. wr_ptr wraps to 0 on that same write.
  - clr=1: next state CLEAR with clr_ptr=0. Any wr_valid in that cycle is not accepted.
- **FULL**
  - wr_ready=0, full=1, and writes are refused.
  - clr=1: next state CLEAR.
- **Read port** (independent of FSM state)
  - rd_en=1: rd_data <= mem[rd_addr] at the edge.
  - rd_en=0: rd_data holds its value.
  - Reads during CLEAR are legal and return current contents, which may be partially zeroed.
- **Same-cycle read and write to one address:** rd_data gets the old contents (read-before-write).
- **Arithmetic:** wr_ptr and clr_ptr are ADDR_W bits wide and wrap modulo DEPTH. count saturates at DEPTH because writes stop in FULL.

## Timing
- **Reset** (rst=1 at an edge):
  - state=CLEAR, clr_ptr=0, wr_ptr=0, count=0, rd_data=0, full=0, busy=1, wr_ready=0.
  - Memory is cleared by the CLEAR pass that follows, not by reset itself.
  - rst overrides clr, rd_en and wr_valid.
- **Reset deasserted:** busy stays 1 for exactly DEPTH cycles (8). wr_ready rises in the cycle after the last clear write.
- **Reset mid-clear or mid-load:** the clear restarts from address 0 and takes the full DEPTH cycles.
- **Write latency:** a word accepted at edge N is readable with rd_en at edge N+1 and appears on rd_data after edge N+1.
- **Read latency:** 1 cycle from rd_en/rd_addr to rd_data.
- **Handshake:**
  - A transfer occurs only on an edge where wr_valid && wr_ready.
  - wr_ready depends only on state and clr; it never depends on wr_valid.
  - The source may hold wr_valid high indefinitely.
- **Back-to-back writes:** one per cycle is sustained. 8 consecutive writes take 8 cycles. full=1 after the 8th write edge, and wr_ready=0 from that point.
- **clr from LOAD or FULL:** busy=1 from the next cycle for DEPTH cycles. count and wr_ptr read 0 only once the pass completes; they keep their old values during CLEAR.

## Test plan
- **Reset and clear:** pulse rst for 1 cycle -> busy=1 for 8 cycles, then wr_ready=1 and count=0; reading addresses 0..7 returns 4'b0000.
- **Stream load:** write 0x0,0x2,0x6,0x9,0x1,0x9,0xC,0xF on consecutive cycles -> full=1, count=8, wr_ptr=0, wr_ready=0; reads of 0..7 return the same sequence with 1-cycle latency.
- **Backpressure and bubbles:**
  - Gapped wr_valid stores only on handshake edges.
  - A 9th word presented while full is never stored; mem[0] still reads 0x0.
- **clr collision:** in LOAD after 3 writes, assert clr and wr_valid (data 0xA) together -> the word is not accepted; busy follows for 8 cycles; then count=0 and all reads return 0.
- **Read-before-write and rd_en hold:**
  - Write 0x5 to addr 0 while reading addr 0 -> rd_data shows the old value, and 0x5 on the next read.
  - rd_en=0 -> rd_data unchanged.
- **Reset mid-clear:** assert rst on the 4th CLEAR cycle -> a fresh 8-cycle busy window starts, with no early wr_ready.
